trap_controller: RTL and testbench
==================================

# trap_controller

Machine-mode trap unit at the commit end of the core pipeline. Consumes the committed exception from the exception pipeline, plus interrupt requests and `mret`. Owns the trap CSRs and performs trap entry and return. Redirects fetch and flushes the pipeline for one cycle per trap or return.

## Interface
Parameters:
- `XLEN`, 32 — data and address width.
- `RESET_MTVEC`, 32'h0000_0000 — reset value of mtvec.

Ports:
- `clk` in 1 — clock, the only clock.
- `rst_sync` in 1 — synchronous, active-high reset.
- `commit_valid` in 1 — an instruction is at the commit point this cycle.
- `commit_pc` in XLEN — PC of that instruction.
- `exc_raise` in 1 — committed exception present; driven from the committed exception's raise field.
- `exc_cause` in 4 — exception code.
- `exc_tval` in XLEN — trap value.
- `mret` in 1 — committing instruction is `mret`.
- `irq_ext` in 1 — level machine external interrupt.
- `irq_timer` in 1 — level machine timer interrupt.
- `csr_we` in 1 — CSR write strobe from the execute stage.
- `csr_addr` in 12 — CSR address.
- `csr_wdata` in XLEN — CSR write data.
- `csr_rdata` out XLEN — combinational read data.
- `trap_flush` out 1 — pipeline flush; registered.
- `redirect_valid` out 1 — fetch redirect; registered.
- `redirect_pc` out XLEN — redirect target; registered.
- `stall_n` out 1 — 0 while the FSM is not IDLE.

## Operation
- FSM states: IDLE, ENTER, RETURN. Reset state is IDLE.
- Transitions out of IDLE, evaluated only when `commit_valid`=1. Priority, highest first:
  - `exc_raise`=1 → ENTER.
  - Interrupt pending → ENTER.
  - `mret`=1 → RETURN.
- ENTER and RETURN each last 1 cycle, then go to IDLE unconditionally. All inputs are ignored in those states.
- Interrupt pending means mstatus.MIE & ((mie.MEIE & `irq_ext`) | (mie.MTIE & `irq_timer`)). External takes priority over timer.
- On the edge that enters ENTER:
  - mepc ← `commit_pc` & ~3.
  - MPIE ← MIE, then MIE ← 0.
  - Exception: mcause ← {0, `exc_cause`}, mtval ← `exc_tval`.
  - Interrupt: mcause ← {1, 11} for external or {1, 7} for timer, mtval ← 0. The interrupted instruction is not retired.
- On the edge that enters RETURN: MIE ← MPIE, MPIE ← 1.
- CSR map:
  - mstatus 0x300: only MIE bit 3 and MPIE bit 7 are writable; MPP bits 12:11 read 2'b11; other bits read 0.
  - mie 0x304: bits 11 and 7 writable.
  - mtvec 0x305.
  - mepc 0x341: bits [1:0] read 0.
  - mcause 0x342.
  - mtval 0x343.
  - mip 0x344: read-only, bit 11 = `irq_ext`, bit 7 = `irq_timer`.
  - Unmapped addresses read 0; writes to them are ignored.
- `csr_we` is honoured only in IDLE with no transition that cycle. When a trap entry or return coincides with a CSR write, the CSR write is dropped.
- Reset values:
  - All CSRs 0, except mtvec = `RESET_MTVEC`.
  - `trap_flush`=0, `redirect_valid`=0, `redirect_pc`=0, `stall_n`=1.

## Timing
- Trigger in cycle N: CSR updates land at edge N+1.
- Cycle N+1 (ENTER or RETURN):
  - `trap_flush`=1, `redirect_valid`=1, `stall_n`=0.
  - `redirect_pc` = trap target in ENTER, mepc in RETURN.
- Cycle N+2: IDLE; outputs back to 0/0/1. Next trap is accepted at the earliest in N+2.
- Trap target: mtvec & ~3.
- `csr_rdata` reflects a CSR write one cycle after the `csr_we` cycle.
- Reset asserted in any state: at the next edge, FSM goes to IDLE and CSRs and outputs take their reset values; any in-flight redirect is dropped.
- Interrupt lines are sampled only in the trigger cycle; no latching. A request deasserted before a `commit_valid` cycle is lost.

## Configuration
- `TRAP_VECTORED_EN` defined:
  - mtvec[1:0] writable.
  - When mtvec[1:0]=01 and the trap is an interrupt, target = (mtvec & ~3) + 4×cause code (external → base+0x2C, timer → base+0x1C).
  - Exceptions always go to the base address.
- `TRAP_VECTORED_EN` undefined: mtvec[1:0] hard-wired to 00; every trap targets the base address.

## Test plan
- Illegal-instruction exception: mtvec=0x100, `commit_pc`=0x2004, cause=2, tval=0xDEAD.
  - → mepc=0x2004, mcause=2, mtval=0xDEAD, MIE=0, MPIE=old MIE.
  - → cycle N+1: flush=1, redirect_pc=0x100.
- Simultaneous `exc_raise`, `irq_timer`, `mret` (MIE=1, MTIE=1) → exception taken; mcause=cause; MIE=0.
- External interrupt: MIE=1, MEIE=1, `irq_ext`=1, `commit_pc`=0x40.
  - → mcause=0x8000_000B, mepc=0x40.
  - With the macro and mtvec=0x101: redirect_pc=0x12C. Without the macro: redirect_pc=0x100.
- `mret` with mepc=0x2008, MPIE=1 → cycle N+1: redirect_pc=0x2008; MIE=1, MPIE=1.
- `csr_we` to mtvec in the same cycle as an exception → write dropped, mtvec unchanged. A write of 0x200 in an IDLE cycle → reads back 0x200 next cycle.
- `rst_sync` asserted during ENTER → next cycle flush=0, stall_n=1, mtvec=`RESET_MTVEC`, mepc=0.

Source files
------------

// File: rtl/trap_controller_if.sv
// Commit-side bus of the machine-mode trap unit: committed instruction/exception,
// interrupt lines, CSR access port and the fetch redirect / flush outputs.
interface trap_controller_if #(
    parameter int XLEN = 32
);
    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic            exc_raise;
    logic [3:0]      exc_cause;
    logic [XLEN-1:0] exc_tval;
    logic            mret;
    logic            irq_ext;
    logic            irq_timer;
    logic            csr_we;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            trap_flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            stall_n;

    modport master (
        output commit_valid, commit_pc, exc_raise, exc_cause, exc_tval, mret,
        output irq_ext, irq_timer, csr_we, csr_addr, csr_wdata,
        input  csr_rdata, trap_flush, redirect_valid, redirect_pc, stall_n
    );

    modport slave (
        input  commit_valid, commit_pc, exc_raise, exc_cause, exc_tval, mret,
        input  irq_ext, irq_timer, csr_we, csr_addr, csr_wdata,
        output csr_rdata, trap_flush, redirect_valid, redirect_pc, stall_n
    );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap unit: owns mstatus/mie/mtvec/mepc/mcause/mtval/mip, performs trap
// entry and mret, and redirects fetch. Optional macro TRAP_VECTORED_EN enables vectored mtvec.
module trap_controller #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
    input  logic             clk,
    input  logic             rst_sync,
    trap_controller_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ENTER, RETURN} state_e;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

`ifdef TRAP_VECTORED_EN
    localparam logic [XLEN-1:0] MTVEC_MASK = '1;
`else
    localparam logic [XLEN-1:0] MTVEC_MASK = ~XLEN'(3);
`endif

    state_e          state_q;
    logic            mstatus_mie_q;
    logic            mstatus_mpie_q;
    logic            mie_meie_q;
    logic            mie_mtie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mtval_q;
    logic            trap_flush_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;

    logic            irq_ext_pend;
    logic            irq_tmr_pend;
    logic            accept;
    logic            take_exc;
    logic            take_irq;
    logic            take_ret;
    logic            csr_wr_en;
    logic [3:0]      irq_code;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target_d;

    assign irq_ext_pend = mstatus_mie_q & mie_meie_q & bus.irq_ext;
    assign irq_tmr_pend = mstatus_mie_q & mie_mtie_q & bus.irq_timer;
    assign accept       = (state_q == IDLE) & bus.commit_valid;
    assign take_exc     = accept & bus.exc_raise;
    assign take_irq     = accept & ~bus.exc_raise & (irq_ext_pend | irq_tmr_pend);
    assign take_ret     = accept & ~bus.exc_raise & ~(irq_ext_pend | irq_tmr_pend) & bus.mret;
    // A CSR write loses to any trap or return decided in the same cycle.
    assign csr_wr_en    = (state_q == IDLE) & bus.csr_we & ~(take_exc | take_irq | take_ret);
    assign irq_code     = irq_ext_pend ? 4'd11 : 4'd7;
    assign trap_base    = {mtvec_q[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign trap_target_d = (take_irq && mtvec_q[1:0] == 2'b01)
                         ? trap_base + XLEN'({irq_code, 2'b00})
                         : trap_base;
`else
    assign trap_target_d = trap_base;
`endif

    always_comb begin
        bus.csr_rdata = '0;
        case (bus.csr_addr)
            ADDR_MSTATUS: begin
                bus.csr_rdata[12:11] = 2'b11;
                bus.csr_rdata[7]     = mstatus_mpie_q;
                bus.csr_rdata[3]     = mstatus_mie_q;
            end
            ADDR_MIE: begin
                bus.csr_rdata[11] = mie_meie_q;
                bus.csr_rdata[7]  = mie_mtie_q;
            end
            ADDR_MTVEC:  bus.csr_rdata = mtvec_q;
            ADDR_MEPC:   bus.csr_rdata = {mepc_q[XLEN-1:2], 2'b00};
            ADDR_MCAUSE: bus.csr_rdata = mcause_q;
            ADDR_MTVAL:  bus.csr_rdata = mtval_q;
            ADDR_MIP: begin
                bus.csr_rdata[11] = bus.irq_ext;
                bus.csr_rdata[7]  = bus.irq_timer;
            end
            default:     bus.csr_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q          <= IDLE;
            mstatus_mie_q    <= 1'b0;
            mstatus_mpie_q   <= 1'b0;
            mie_meie_q       <= 1'b0;
            mie_mtie_q       <= 1'b0;
            mtvec_q          <= RESET_MTVEC & MTVEC_MASK;
            mepc_q           <= '0;
            mcause_q         <= '0;
            mtval_q          <= '0;
            trap_flush_q     <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            trap_flush_q     <= 1'b0;
            redirect_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take_exc || take_irq) begin
                        state_q          <= ENTER;
                        trap_flush_q     <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= trap_target_d;
                        mepc_q           <= {bus.commit_pc[XLEN-1:2], 2'b00};
                        mstatus_mpie_q   <= mstatus_mie_q;
                        mstatus_mie_q    <= 1'b0;
                        if (take_exc) begin
                            mcause_q <= {1'b0, {(XLEN-5){1'b0}}, bus.exc_cause};
                            mtval_q  <= bus.exc_tval;
                        end else begin
                            mcause_q <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
                            mtval_q  <= '0;
                        end
                    end else if (take_ret) begin
                        state_q          <= RETURN;
                        trap_flush_q     <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= {mepc_q[XLEN-1:2], 2'b00};
                        mstatus_mie_q    <= mstatus_mpie_q;
                        mstatus_mpie_q   <= 1'b1;
                    end else if (csr_wr_en) begin
                        case (bus.csr_addr)
                            ADDR_MSTATUS: begin
                                mstatus_mie_q  <= bus.csr_wdata[3];
                                mstatus_mpie_q <= bus.csr_wdata[7];
                            end
                            ADDR_MIE: begin
                                mie_meie_q <= bus.csr_wdata[11];
                                mie_mtie_q <= bus.csr_wdata[7];
                            end
                            ADDR_MTVEC:  mtvec_q  <= bus.csr_wdata & MTVEC_MASK;
                            ADDR_MEPC:   mepc_q   <= {bus.csr_wdata[XLEN-1:2], 2'b00};
                            ADDR_MCAUSE: mcause_q <= bus.csr_wdata;
                            ADDR_MTVAL:  mtval_q  <= bus.csr_wdata;
                            default: ;
                        endcase
                    end
                end
                ENTER, RETURN: state_q <= IDLE;
                default:       state_q <= IDLE;
            endcase
        end
    end

    assign bus.trap_flush     = trap_flush_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.stall_n        = (state_q == IDLE);
endmodule

// File: tb/tb_trap_controller.sv
// Directed testbench for trap_controller: exception/interrupt entry, mret, CSR write
// dropping, input ignoring during ENTER and reset during ENTER.
module tb_trap_controller;
    localparam logic [31:0] RST_VEC = 32'h0000_0080;

    logic clk = 1'b0;
    logic rst_sync;
    int   n_vec = 0;
    int   n_err = 0;

    trap_controller_if #(.XLEN(32)) bus ();

    trap_controller #(.XLEN(32), .RESET_MTVEC(RST_VEC)) dut (
        .clk      (clk),
        .rst_sync (rst_sync),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.commit_valid = 1'b0;
        bus.commit_pc    = '0;
        bus.exc_raise    = 1'b0;
        bus.exc_cause    = '0;
        bus.exc_tval     = '0;
        bus.mret         = 1'b0;
        bus.csr_we       = 1'b0;
        bus.csr_addr     = '0;
        bus.csr_wdata    = '0;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        bus.csr_we    = 1'b1;
        bus.csr_addr  = a;
        bus.csr_wdata = d;
        step();
        bus.csr_we    = 1'b0;
    endtask

    task automatic csr_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        @(negedge clk);
        bus.csr_addr = a;
        #1;
        check_val(tag, bus.csr_rdata, exp);
    endtask

    task automatic chk_outs(input string tag, input logic fl, input logic rv, input logic sn);
        check_val({tag, "_flush"},  {31'd0, bus.trap_flush},     {31'd0, fl});
        check_val({tag, "_rvalid"}, {31'd0, bus.redirect_valid}, {31'd0, rv});
        check_val({tag, "_stalln"}, {31'd0, bus.stall_n},        {31'd0, sn});
    endtask

    initial begin
        logic [31:0] exp_vec_pc;
        logic [31:0] exp_mtvec101;
`ifdef TRAP_VECTORED_EN
        exp_vec_pc   = 32'h0000_012C;
        exp_mtvec101 = 32'h0000_0101;
`else
        exp_vec_pc   = 32'h0000_0100;
        exp_mtvec101 = 32'h0000_0100;
`endif
        clear_inputs();
        bus.irq_ext   = 1'b0;
        bus.irq_timer = 1'b0;
        rst_sync      = 1'b1;
        step();
        step();
        rst_sync = 1'b0;

        // Reset state
        chk_outs("rst", 1'b0, 1'b0, 1'b1);
        check_val("rst_rpc", bus.redirect_pc, 32'h0);
        csr_chk("rst_mtvec",   12'h305, RST_VEC);
        csr_chk("rst_mstatus", 12'h300, 32'h0000_1800);
        csr_chk("rst_mepc",    12'h341, 32'h0);
        csr_chk("rst_mcause",  12'h342, 32'h0);

        // Illegal instruction with a simultaneous (dropped) mtvec write
        csr_wr(12'h305, 32'h0000_0100);
        csr_chk("mtvec_wr", 12'h305, 32'h0000_0100);
        csr_wr(12'h300, 32'h0000_0008);
        bus.commit_valid = 1'b1; bus.commit_pc = 32'h2004;
        bus.exc_raise = 1'b1; bus.exc_cause = 4'd2; bus.exc_tval = 32'hDEAD;
        bus.csr_we = 1'b1; bus.csr_addr = 12'h305; bus.csr_wdata = 32'h0000_0300;
        step();
        clear_inputs();
        chk_outs("exc_n1", 1'b1, 1'b1, 1'b0);
        check_val("exc_rpc", bus.redirect_pc, 32'h0000_0100);
        step();
        chk_outs("exc_n2", 1'b0, 1'b0, 1'b1);
        csr_chk("exc_mepc",    12'h341, 32'h0000_2004);
        csr_chk("exc_mcause",  12'h342, 32'h0000_0002);
        csr_chk("exc_mtval",   12'h343, 32'h0000_DEAD);
        csr_chk("exc_mstatus", 12'h300, 32'h0000_1880);
        csr_chk("exc_mtvec_drop", 12'h305, 32'h0000_0100);

        // Exception beats timer interrupt and mret
        csr_wr(12'h300, 32'h0000_0008);
        csr_wr(12'h304, 32'h0000_0080);
        bus.irq_timer = 1'b1;
        bus.commit_valid = 1'b1; bus.commit_pc = 32'h3000; bus.mret = 1'b1;
        bus.exc_raise = 1'b1; bus.exc_cause = 4'd5; bus.exc_tval = 32'h1234;
        step();
        clear_inputs();
        bus.irq_timer = 1'b0;
        check_val("pri_rpc", bus.redirect_pc, 32'h0000_0100);
        step();
        csr_chk("pri_mcause",  12'h342, 32'h0000_0005);
        csr_chk("pri_mstatus", 12'h300, 32'h0000_1880);

        // External interrupt, possibly vectored
        csr_wr(12'h300, 32'h0000_0008);
        csr_wr(12'h304, 32'h0000_0800);
        csr_wr(12'h305, 32'h0000_0101);
        csr_chk("mtvec_101", 12'h305, exp_mtvec101);
        bus.irq_ext = 1'b1;
        csr_chk("mip_ext", 12'h344, 32'h0000_0800);
        step();
        chk_outs("nocv", 1'b0, 1'b0, 1'b1);
        bus.commit_valid = 1'b1; bus.commit_pc = 32'h40;
        step();
        clear_inputs();
        bus.irq_ext = 1'b0;
        chk_outs("irq_n1", 1'b1, 1'b1, 1'b0);
        check_val("irq_rpc", bus.redirect_pc, exp_vec_pc);
        step();
        csr_chk("irq_mcause",  12'h342, 32'h8000_000B);
        csr_chk("irq_mepc",    12'h341, 32'h0000_0040);
        csr_chk("irq_mtval",   12'h343, 32'h0);
        csr_chk("irq_mstatus", 12'h300, 32'h0000_1880);

        // mret back to a written mepc (low bits masked)
        csr_wr(12'h341, 32'h0000_200B);
        csr_chk("mepc_mask", 12'h341, 32'h0000_2008);
        bus.commit_valid = 1'b1; bus.mret = 1'b1;
        step();
        clear_inputs();
        chk_outs("ret_n1", 1'b1, 1'b1, 1'b0);
        check_val("ret_rpc", bus.redirect_pc, 32'h0000_2008);
        step();
        csr_chk("ret_mstatus", 12'h300, 32'h0000_1888);

        // Held trigger: ignored in ENTER, accepted again in N+2
        bus.commit_valid = 1'b1; bus.exc_raise = 1'b1; bus.exc_cause = 4'd3;
        step();
        chk_outs("hold_n1", 1'b1, 1'b1, 1'b0);
        step();
        chk_outs("hold_n2", 1'b0, 1'b0, 1'b1);
        step();
        chk_outs("hold_n3", 1'b1, 1'b1, 1'b0);
        clear_inputs();
        step();

        // Idle write then reset during ENTER
        csr_wr(12'h305, 32'h0000_0200);
        csr_chk("mtvec_200", 12'h305, 32'h0000_0200);
        bus.commit_valid = 1'b1; bus.commit_pc = 32'h5000; bus.exc_raise = 1'b1;
        step();
        clear_inputs();
        rst_sync = 1'b1;
        step();
        rst_sync = 1'b0;
        chk_outs("rst_enter", 1'b0, 1'b0, 1'b1);
        csr_chk("rst_enter_mtvec", 12'h305, RST_VEC);
        csr_chk("rst_enter_mepc",  12'h341, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
